branch_target_buffer: RTL and testbench
=======================================

// Module: branch_target_buffer
// PURPOSE
//  Direct-mapped, parametrised branch target buffer with per-entry saturating counters.
//  Fetch presents the current PC; a registered table returns hit, taken prediction and target
//  combinationally, so fetch selects NPC in the same cycle.
//  Branch resolution (EX/MEM) writes back the actual outcome.
//  Successor to the four-entry always-taken predictor: adds depth/width parameters,
//  dynamic direction, allocation and flush.
// PARAMETERS
//  ENTRIES   16  table depth; power of 2, >=2; IDX_W = $clog2(ENTRIES)
//  CTR_W     2   saturating-counter width (>=1); predict taken when MSB=1
//  ALLOC_NT  0   1: also allocate on not-taken misses; 0: allocate only on taken
// PORTS
//  CLK          in   1       system clock, rising edge
//  nRST         in   1       asynchronous active-low reset
//  curr_pc      in   32      fetch-stage PC (word aligned)
//  pred_hit     out  1       valid entry with matching tag for curr_pc
//  pred_taken   out  1       pred_hit && counter MSB
//  pred_target  out  32      stored target; 0 when !pred_hit
//  upd_en       in   1       resolution-stage update strobe, one per resolved branch
//  upd_pc       in   32      PC of the resolved branch
//  upd_taken    in   1       actual direction
//  upd_target   in   32      actual taken target
//  flush        in   1       synchronous invalidate of all entries
// BEHAVIOUR
//  - Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2] (TAG_W = 30-IDX_W). Bits [1:0] are ignored.
//  - Lookup is purely combinational from registered state; zero-cycle latency.
//  - No write-to-read bypass: an update at edge N becomes visible to lookup after edge N.
//  - Reset (async, nRST=0): every valid=0, tag=0, target=0, counter=WEAK_NT (01 for CTR_W=2).
//    All outputs read 0 while reset is held and until the first allocation.
//  - Update (upd_en=1, !flush) at index i, uhit = valid[i] && tag[i]==upd_tag:
//    * uhit && taken: counter +1, saturating at all-ones; target <= upd_target.
//    * uhit && !taken: counter -1, saturating at 0; target unchanged.
//    * !uhit && taken: allocate; valid=1, tag, target <= upd_target, counter=WEAK_T (10).
//      Any previous occupant is overwritten.
//    * !uhit && !taken: if ALLOC_NT, allocate with counter=WEAK_NT and target=upd_target;
//      else no change.
//  - flush=1: all valid <= 0 at the edge; counters, tags and targets are retained.
//    Flush wins over a simultaneous upd_en, and that update is dropped.
//  - Lookup and update of the same index in one cycle: lookup returns pre-update state.
//  - Counter arithmetic is CTR_W bits and never wraps: inc at max, or dec at 0, holds.
//  - CTR_W=1: WEAK_T=1, WEAK_NT=0, so the counter is a last-outcome bit.
//  - Reset asserted mid-operation clears the table regardless of upd_en/flush.
// STRUCTURE
//  - cpu_types_pkg: word_t, and counter encoding constants BTB_WEAK_NT/BTB_WEAK_T
//    expressed for CTR_W=2. The block derives general values as {1'b0,{(CTR_W-1){1'b1}}}
//    and {1'b1,{(CTR_W-1){1'b0}}}.
//  - Entry struct {valid, tag, target, ctr} is local, since its widths depend on parameters.
//  - Sub-module sat_counter #(W): next-value logic (inc/dec/hold, saturating), one per entry.
//  - Table is a flop array (not SRAM), so flush and reset complete in one cycle.
// TESTING (ENTRIES=16, CTR_W=2, ALLOC_NT=0 unless stated)
//  1. Reset, curr_pc=0x40 -> pred_hit=0, pred_taken=0, pred_target=0.
//  2. upd pc=0x40 taken tgt=0x100; next cycle curr_pc=0x40 -> hit=1, taken=1, target=0x100.
//     curr_pc=0x440 (same idx, other tag) -> hit=0.
//  3. From (2): 2x not-taken at 0x40 -> counter 10->01->00, pred_taken=0, hit=1.
//     3x taken -> 01,10,11, and a 4th taken holds at 11.
//  4. Same-cycle lookup and update of 0x40 (counter 01, upd taken) -> pred_taken=0 that cycle,
//     1 the next. Allocating 0x440 taken tgt=0x200 evicts 0x40.
//  5. flush with upd_en at 0x80 taken -> all hits 0, 0x80 not allocated.
//     nRST pulse mid-sequence -> all outputs 0 immediately.
//  6. ALLOC_NT=1: upd 0x8 not-taken tgt=0x30 -> hit=1, taken=0, target=0x30.
//     CTR_W=3 allocate taken -> counter 100.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types plus the branch-target-buffer counter encodings.
// The counter constants are given for a 2-bit counter.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   localparam logic [1:0] BTB_WEAK_NT = 2'b01;
   localparam logic [1:0] BTB_WEAK_T  = 2'b10;

   typedef enum logic [1:0] {
      CTR_HOLD = 2'b00,
      CTR_INC  = 2'b01,
      CTR_DEC  = 2'b10
   } ctr_op_e;

endpackage

// File: rtl/sat_counter.sv
// Next-value logic for one saturating direction counter.
// The counter register itself belongs to the owning table entry.
module sat_counter
   import cpu_types_pkg::*;
#(
   parameter int W = 2
) (
   input  logic [W-1:0] i_ctr,
   input  ctr_op_e      i_op,
   output logic [W-1:0] o_next
);

   always_comb begin
      o_next = i_ctr;
      case (i_op)
         CTR_INC: if (i_ctr != {W{1'b1}}) o_next = i_ctr + W'(1);
         CTR_DEC: if (i_ctr != {W{1'b0}}) o_next = i_ctr - W'(1);
         default: o_next = i_ctr;
      endcase
   end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Lookup is combinational from the flop table; updates land on the next clock edge.
module branch_target_buffer
   import cpu_types_pkg::*;
#(
   parameter int ENTRIES  = 16,
   parameter int CTR_W    = 2,
   parameter bit ALLOC_NT = 1'b0
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic [31:0] curr_pc,
   output logic        pred_hit,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        upd_en,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        flush
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = 30 - IDX_W;

   // Weak-taken is the MSB alone; weak-not-taken is every bit below it.
   localparam int unsigned WEAK_T_I = 1 << (CTR_W - 1);
   localparam int unsigned WEAK_NT_I = WEAK_T_I - 1;
   localparam logic [CTR_W-1:0] WEAK_T  = WEAK_T_I[CTR_W-1:0];
   localparam logic [CTR_W-1:0] WEAK_NT = WEAK_NT_I[CTR_W-1:0];

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      word_t            target;
      logic [CTR_W-1:0] ctr;
   } entry_t;

   entry_t           w_entries [ENTRIES];
   logic [IDX_W-1:0] w_upd_idx;
   logic [TAG_W-1:0] w_upd_tag;
   logic [IDX_W-1:0] w_cur_idx;
   logic [TAG_W-1:0] w_cur_tag;
   entry_t           w_look;
   logic             w_unused;

   assign w_upd_idx = upd_pc[IDX_W+1:2];
   assign w_upd_tag = upd_pc[31:IDX_W+2];
   assign w_cur_idx = curr_pc[IDX_W+1:2];
   assign w_cur_tag = curr_pc[31:IDX_W+2];
   assign w_unused  = ^{curr_pc[1:0], upd_pc[1:0]};

   genvar gi;
   generate
      for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
         entry_t           r_entry;
         logic             w_sel;
         logic             w_uhit;
         ctr_op_e          w_op;
         logic [CTR_W-1:0] w_ctr_next;

         assign w_sel  = upd_en && !flush && (w_upd_idx == IDX_W'(gi));
         assign w_uhit = r_entry.valid && (r_entry.tag == w_upd_tag);
         assign w_op   = upd_taken ? CTR_INC : CTR_DEC;

         sat_counter #(.W(CTR_W)) u_ctr (
            .i_ctr  (r_entry.ctr),
            .i_op   (w_op),
            .o_next (w_ctr_next)
         );

         always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
               r_entry.valid  <= 1'b0;
               r_entry.tag    <= '0;
               r_entry.target <= '0;
               r_entry.ctr    <= WEAK_NT;
            end else if (flush) begin
               // Only validity is cleared; stale contents are harmless once invalid.
               r_entry.valid <= 1'b0;
            end else if (w_sel) begin
               if (w_uhit) begin
                  r_entry.ctr <= w_ctr_next;
                  if (upd_taken) r_entry.target <= upd_target;
               end else if (upd_taken || ALLOC_NT) begin
                  r_entry.valid  <= 1'b1;
                  r_entry.tag    <= w_upd_tag;
                  r_entry.target <= upd_target;
                  r_entry.ctr    <= upd_taken ? WEAK_T : WEAK_NT;
               end
            end
         end

         assign w_entries[gi] = r_entry;
      end
   endgenerate

   assign w_look      = w_entries[w_cur_idx];
   assign pred_hit    = w_look.valid && (w_look.tag == w_cur_tag);
   assign pred_taken  = pred_hit && w_look.ctr[CTR_W-1];
   assign pred_target = pred_hit ? w_look.target : 32'h0;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer: default build, allocate-on-not-taken build
// and a 3-bit counter build, all driven from one shared stimulus stream.
module tb_branch_target_buffer;

   logic        CLK = 1'b0;
   logic        nRST;
   logic [31:0] curr_pc;
   logic        upd_en;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        flush;

   logic        hit0, tkn0, hit1, tkn1, hit2, tkn2;
   logic [31:0] tgt0, tgt1, tgt2;

   int n_total = 0;
   int n_bad   = 0;

   always #5 CLK = ~CLK;

   branch_target_buffer #(.ENTRIES(16), .CTR_W(2), .ALLOC_NT(1'b0)) u_dut (
      .CLK(CLK), .nRST(nRST), .curr_pc(curr_pc),
      .pred_hit(hit0), .pred_taken(tkn0), .pred_target(tgt0),
      .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .upd_target(upd_target), .flush(flush)
   );

   branch_target_buffer #(.ENTRIES(16), .CTR_W(2), .ALLOC_NT(1'b1)) u_dut_ant (
      .CLK(CLK), .nRST(nRST), .curr_pc(curr_pc),
      .pred_hit(hit1), .pred_taken(tkn1), .pred_target(tgt1),
      .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .upd_target(upd_target), .flush(flush)
   );

   branch_target_buffer #(.ENTRIES(16), .CTR_W(3), .ALLOC_NT(1'b0)) u_dut_c3 (
      .CLK(CLK), .nRST(nRST), .curr_pc(curr_pc),
      .pred_hit(hit2), .pred_taken(tkn2), .pred_target(tgt2),
      .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .upd_target(upd_target), .flush(flush)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%08h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
      upd_en = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
      tick();
      upd_en = 1'b0;
      #1;
   endtask

   task automatic look(input string tag, input logic [31:0] pc,
                       input logic eh, input logic et, input logic [31:0] etgt);
      curr_pc = pc;
      #1;
      check({tag, ".hit"}, {31'd0, hit0}, {31'd0, eh});
      check({tag, ".taken"}, {31'd0, tkn0}, {31'd0, et});
      check({tag, ".target"}, tgt0, etgt);
   endtask

   initial begin
      nRST = 1'b0; curr_pc = 32'h40; upd_en = 1'b0; upd_pc = '0;
      upd_taken = 1'b0; upd_target = '0; flush = 1'b0;

      // 1: reset held, then released with nothing allocated
      #3;
      look("rst_held", 32'h40, 1'b0, 1'b0, 32'h0);
      tick(); tick();
      @(negedge CLK); nRST = 1'b1;
      look("rst_rel", 32'h40, 1'b0, 1'b0, 32'h0);

      // 2: allocate taken, alias on same index with different tag misses
      upd(32'h40, 1'b1, 32'h100);
      look("alloc", 32'h40, 1'b1, 1'b1, 32'h100);
      look("low_bits_ignored", 32'h43, 1'b1, 1'b1, 32'h100);
      look("alias_miss", 32'h440, 1'b0, 1'b0, 32'h0);

      // 3: counter walk 10->01->00->01->10->11, saturate at 11, then back down
      upd(32'h40, 1'b0, 32'hdead);
      look("nt1_ctr01", 32'h40, 1'b1, 1'b0, 32'h100);
      upd(32'h40, 1'b0, 32'hdead);
      look("nt2_ctr00", 32'h40, 1'b1, 1'b0, 32'h100);
      upd(32'h40, 1'b1, 32'h100);
      look("t1_ctr01", 32'h40, 1'b1, 1'b0, 32'h100);
      upd(32'h40, 1'b1, 32'h100);
      look("t2_ctr10", 32'h40, 1'b1, 1'b1, 32'h100);
      upd(32'h40, 1'b1, 32'h100);
      look("t3_ctr11", 32'h40, 1'b1, 1'b1, 32'h100);
      upd(32'h40, 1'b1, 32'h180);
      look("t4_sat11_newtgt", 32'h40, 1'b1, 1'b1, 32'h180);
      upd(32'h40, 1'b0, 32'h0);
      look("nt_after_sat_ctr10", 32'h40, 1'b1, 1'b1, 32'h180);
      upd(32'h40, 1'b0, 32'h0);
      look("nt_ctr01", 32'h40, 1'b1, 1'b0, 32'h180);

      // 4: same-cycle lookup sees pre-update state
      curr_pc = 32'h40;
      upd_en = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h180;
      #1;
      check("same_cycle_pre.taken", {31'd0, tkn0}, 32'd0);
      tick();
      upd_en = 1'b0;
      look("same_cycle_post", 32'h40, 1'b1, 1'b1, 32'h180);
      upd(32'h440, 1'b1, 32'h200);
      look("evicted", 32'h40, 1'b0, 1'b0, 32'h0);
      look("evictor", 32'h440, 1'b1, 1'b1, 32'h200);

      // 5: flush beats a simultaneous update
      flush = 1'b1;
      upd(32'h80, 1'b1, 32'h300);
      flush = 1'b0;
      look("flush_old", 32'h440, 1'b0, 1'b0, 32'h0);
      look("flush_dropped_upd", 32'h80, 1'b0, 1'b0, 32'h0);
      upd(32'h80, 1'b1, 32'h300);
      look("post_flush_alloc", 32'h80, 1'b1, 1'b1, 32'h300);
      #2 nRST = 1'b0;
      #1;
      check("midrst.hit", {31'd0, hit0}, 32'd0);
      check("midrst.target", tgt0, 32'h0);
      #2 nRST = 1'b1;
      look("after_midrst", 32'h80, 1'b0, 1'b0, 32'h0);

      // 6: not-taken allocation only in the ALLOC_NT build; 3-bit counter starts at 100
      upd(32'h8, 1'b0, 32'h30);
      curr_pc = 32'h8;
      #1;
      check("nt_noalloc.hit", {31'd0, hit0}, 32'd0);
      check("ant.hit", {31'd0, hit1}, 32'd1);
      check("ant.taken", {31'd0, tkn1}, 32'd0);
      check("ant.target", tgt1, 32'h30);
      upd(32'h8, 1'b1, 32'h50);
      check("ant_inc.taken", {31'd0, tkn1}, 32'd1);
      check("c3_alloc.hit", {31'd0, hit2}, 32'd1);
      check("c3_alloc.taken", {31'd0, tkn2}, 32'd1);
      check("c3_alloc.target", tgt2, 32'h50);
      upd(32'h8, 1'b0, 32'h0);
      check("c3_dec011.taken", {31'd0, tkn2}, 32'd0);
      check("c3_dec011.hit", {31'd0, hit2}, 32'd1);
      upd(32'h8, 1'b1, 32'h50);
      check("c3_inc100.taken", {31'd0, tkn2}, 32'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
